// File: rtl/sr04_array.sv
// Multi-channel SR-04 ranging controller: round-robin trigger, echo width to cm, optional speed.
// Optional closing-speed datapath is enabled by defining SR04_SPEED_EN.
module sr04_array #(
  parameter int CH_NUM     = 2,
  parameter int TICK_DIV   = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int DIST_W     = 14
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CH_NUM-1:0]            echo,
  output logic [CH_NUM-1:0]            trig,
  output logic [CH_NUM*DIST_W-1:0]     distance,
  output logic [CH_NUM*(DIST_W+1)-1:0] speed,
  output logic [CH_NUM-1:0]            valid,
  output logic [CH_NUM-1:0]            timeout
);

  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TRIG_W = $clog2(TRIG_US + 1);
  localparam int TO_W   = $clog2(TIMEOUT_US + 1);
  localparam int PER_W  = $clog2(PERIOD_US + 1);
  localparam int PRE_W  = 6;
  localparam logic [DIST_W-1:0] DIST_SAT = {{(DIST_W-1){1'b1}}, 1'b0};
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CH_NUM - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, GAP} state_t;

  state_t                          state;
  logic [CH_W-1:0]                 ch;
  logic [CH_W-1:0]                 ch_nxt;
  logic [DIV_W-1:0]                div_cnt;
  logic                            us_tick;
  logic [TRIG_W-1:0]               trig_cnt;
  logic [TO_W-1:0]                 to_cnt;
  logic [PER_W-1:0]                per_cnt;
  logic [PRE_W-1:0]                pre_cnt;
  logic [DIST_W-1:0]               dist_acc;
  logic [DIST_W-1:0]               acc_nxt;
  logic                            pre_wrap;
  logic [CH_NUM-1:0]               echo_s1;
  logic [CH_NUM-1:0]               echo_s2;
  logic [CH_NUM-1:0]               echo_s3;
  logic                            echo_rise;
  logic                            echo_fall;
  logic                            to_hit;
  logic                            pub_good;
  logic                            pub_to;
  logic [CH_NUM-1:0][DIST_W-1:0]   dist_q;

  // valid is a one-cycle strobe with no back-pressure: the consumer samples distance,
  // speed and timeout of that channel while valid is high; they hold until the next publish.
  assign distance = dist_q;

  assign us_tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (us_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_s3 <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  // Both edges come from the same synced pair, so the measured width equals the pin width.
  assign echo_rise = echo_s2[ch] & ~echo_s3[ch];
  assign echo_fall = ~echo_s2[ch] & echo_s3[ch];

  assign ch_nxt   = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
  assign to_hit   = us_tick && (to_cnt == TO_W'(TIMEOUT_US - 1));
  assign pub_good = (state == MEAS) && echo_fall;
  assign pub_to   = ((state == WAIT) || (state == MEAS)) && to_hit && !pub_good;

  // The tick landing on the falling-edge cycle is folded into the published value.
  assign pre_wrap = us_tick && (pre_cnt == PRE_W'(57));
  assign acc_nxt  = (pre_wrap && (dist_acc != DIST_SAT)) ? dist_acc + DIST_W'(1) : dist_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= '0;
      trig     <= '0;
      trig_cnt <= '0;
      to_cnt   <= '0;
      per_cnt  <= '0;
      pre_cnt  <= '0;
      dist_acc <= '0;
      dist_q   <= '0;
      valid    <= '0;
      timeout  <= '0;
    end else begin
      valid <= '0;
      if ((state != IDLE) && us_tick) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
      case (state)
        IDLE: begin
          if (us_tick) begin
            trig     <= '0;
            trig[ch] <= 1'b1;
            trig_cnt <= '0;
            per_cnt  <= '0;
            state    <= TRIG;
          end
        end
        TRIG: begin
          if (us_tick) begin
            if (trig_cnt == TRIG_W'(TRIG_US - 1)) begin
              trig   <= '0;
              to_cnt <= '0;
              state  <= WAIT;
            end else begin
              trig_cnt <= trig_cnt + TRIG_W'(1);
            end
          end
        end
        WAIT: begin
          if (pub_to) begin
            dist_q[ch]  <= '1;
            timeout[ch] <= 1'b1;
            valid[ch]   <= 1'b1;
            state       <= GAP;
          end else begin
            if (us_tick) begin
              to_cnt <= to_cnt + TO_W'(1);
            end
            if (echo_rise) begin
              pre_cnt  <= '0;
              dist_acc <= '0;
              state    <= MEAS;
            end
          end
        end
        MEAS: begin
          if (pub_good) begin
            dist_q[ch]  <= acc_nxt;
            timeout[ch] <= 1'b0;
            valid[ch]   <= 1'b1;
            state       <= GAP;
          end else if (pub_to) begin
            dist_q[ch]  <= '1;
            timeout[ch] <= 1'b1;
            valid[ch]   <= 1'b1;
            state       <= GAP;
          end else begin
            if (us_tick) begin
              to_cnt  <= to_cnt + TO_W'(1);
              pre_cnt <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
            end
            dist_acc <= acc_nxt;
          end
        end
        GAP: begin
          if (us_tick && (per_cnt == PER_W'(PERIOD_US - 1))) begin
            ch           <= ch_nxt;
            trig         <= '0;
            trig[ch_nxt] <= 1'b1;
            trig_cnt     <= '0;
            per_cnt      <= '0;
            state        <= TRIG;
          end
        end
        default: begin
          trig  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SR04_SPEED_EN
  logic [CH_NUM-1:0][DIST_W-1:0] prev_q;
  logic [CH_NUM-1:0]             hist_q;
  logic [CH_NUM-1:0][DIST_W:0]   speed_q;

  assign speed = speed_q;

  // Zero-extended subtraction in DIST_W+1 bits is already the signed delta.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      hist_q  <= '0;
      speed_q <= '0;
    end else if (pub_good) begin
      speed_q[ch] <= hist_q[ch] ? ({1'b0, acc_nxt} - {1'b0, prev_q[ch]}) : '0;
      prev_q[ch]  <= acc_nxt;
      hist_q[ch]  <= 1'b1;
    end else if (pub_to) begin
      hist_q[ch] <= 1'b0;
    end
  end
`else
  assign speed = '0;
`endif

endmodule
